// File: rtl/rmw_seq_pkg.sv
// Shared CPU types: RMW opcodes, ALU opcodes, 6502 status register layout
// and the RMW sequencer state encoding.
package cpu_types;

  typedef enum logic [2:0] {
    RMW_ASL, RMW_LSR, RMW_ROL, RMW_ROR, RMW_INC, RMW_DEC
  } rmwop_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SL, ALU_SR, ALU_ROL, ALU_ROR
  } aluop_t;

  // Bit order matches the 6502 P register: N V - B D I Z C
  typedef struct packed {
    logic n;
    logic v;
    logic u;
    logic b;
    logic d;
    logic i;
    logic z;
    logic c;
  } statusReg_t;

  typedef enum logic [2:0] {
    IDLE, READ, LATCH, DUMMY, WRITE, DONE
  } rmw_state_t;

  localparam logic [7:0] INC_B = 8'h01;
  localparam logic [7:0] DEC_B = 8'hFF;

endpackage

// File: rtl/rmw_seq_if.sv
// Request, CPU-bus and completion signals of the RMW sequencer.
interface rmw_seq_if;
  import cpu_types::*;

  logic        start;
  rmwop_t      op;
  logic [15:0] addr;
  statusReg_t  status_in;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        done;
  logic [7:0]  result;
  statusReg_t  status_out;
  logic        status_we;

  modport slave (
    input  start, op, addr, status_in, mem_rdata,
    output mem_addr, mem_re, mem_we, mem_wdata, busy, done, result,
           status_out, status_we
  );

  modport master (
    output start, op, addr, status_in, mem_rdata,
    input  mem_addr, mem_re, mem_we, mem_wdata, busy, done, result,
           status_out, status_we
  );

endinterface

// File: rtl/rmw_seq_alu.sv
// Combinational ALU shared by all RMW operations: add with carry-in,
// shifts and rotates through carry, plus N/Z derived from the result.
module alu
  import cpu_types::*;
#(
  parameter int DATA_W = 8
) (
  input  aluop_t            op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] y,
  output logic              cout,
  output logic              n,
  output logic              z
);

  always_comb begin
    y    = '0;
    cout = 1'b0;
    case (op)
      ALU_ADD: {cout, y} = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
      ALU_SL:  {cout, y} = {a, 1'b0};
      ALU_SR:  {y, cout} = {1'b0, a};
      ALU_ROL: {cout, y} = {a, cin};
      ALU_ROR: {y, cout} = {cin, a};
      default: ;
    endcase
  end

  assign n = y[DATA_W-1];
  assign z = (y == '0);

endmodule

// File: rtl/rmw_seq.sv
// 6502-style read-modify-write sequencer: READ, LATCH, DUMMY, WRITE, DONE.
// Define RMW_DUMMY_WRITE_EN to write the unmodified operand back in DUMMY.
module rmw_seq
  import cpu_types::*;
(
  input logic       clk,
  input logic       rst,
  rmw_seq_if.slave  bus
);

`ifdef RMW_DUMMY_WRITE_EN
  localparam logic DUMMY_WE = 1'b1;
`else
  localparam logic DUMMY_WE = 1'b0;
`endif

  rmw_state_t state;
  rmwop_t     op_q;
  statusReg_t status_q;
  statusReg_t status_next;
  logic [7:0] operand_q;

  aluop_t     alu_op;
  logic [7:0] alu_b;
  logic [7:0] alu_y;
  logic       alu_cin;
  logic       alu_cout;
  logic       alu_n;
  logic       alu_z;

  alu #(.DATA_W(8)) u_alu (
    .op   (alu_op),
    .a    (operand_q),
    .b    (alu_b),
    .cin  (alu_cin),
    .y    (alu_y),
    .cout (alu_cout),
    .n    (alu_n),
    .z    (alu_z)
  );

  // Shifts/rotates own the carry; INC/DEC leave C and V as captured.
  always_comb begin
    alu_op        = ALU_ADD;
    alu_b         = 8'h00;
    alu_cin       = status_q.c;
    status_next   = status_q;
    status_next.n = alu_n;
    status_next.z = alu_z;
    case (op_q)
      RMW_ASL: begin alu_op = ALU_SL;  status_next.c = alu_cout; end
      RMW_LSR: begin alu_op = ALU_SR;  status_next.c = alu_cout; end
      RMW_ROL: begin alu_op = ALU_ROL; status_next.c = alu_cout; end
      RMW_ROR: begin alu_op = ALU_ROR; status_next.c = alu_cout; end
      RMW_INC: begin alu_op = ALU_ADD; alu_b = INC_B; alu_cin = 1'b0; end
      RMW_DEC: begin alu_op = ALU_ADD; alu_b = DEC_B; alu_cin = 1'b0; end
      default: ;
    endcase
  end

  // Operand/request capture carries no control meaning, so it is not reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      op_q     <= bus.op;
      status_q <= bus.status_in;
    end
    if (state == LATCH) begin
      operand_q <= bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.status_we  <= 1'b0;
      bus.mem_re     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.result     <= '0;
      bus.status_out <= '0;
    end else begin
      bus.done      <= 1'b0;
      bus.status_we <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= READ;
            bus.busy     <= 1'b1;
            bus.mem_addr <= bus.addr;
            bus.mem_re   <= 1'b1;
          end
        end
        READ: begin
          state      <= LATCH;
          bus.mem_re <= 1'b0;
        end
        LATCH: begin
          state         <= DUMMY;
          bus.mem_we    <= DUMMY_WE;
          bus.mem_wdata <= bus.mem_rdata;
        end
        DUMMY: begin
          state          <= WRITE;
          bus.mem_we     <= 1'b1;
          bus.mem_wdata  <= alu_y;
          bus.result     <= alu_y;
          bus.status_out <= status_next;
        end
        WRITE: begin
          state         <= DONE;
          bus.busy      <= 1'b0;
          bus.mem_we    <= 1'b0;
          bus.mem_addr  <= '0;
          bus.mem_wdata <= '0;
          bus.done      <= 1'b1;
          bus.status_we <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rmw_seq.sv
// Scoreboard bench for rmw_seq: directed RMW vectors, held start, mid-op reset.
module tb_rmw_seq;
  import cpu_types::*;

`ifdef RMW_DUMMY_WRITE_EN
  localparam int EXP_WE = 2;
`else
  localparam int EXP_WE = 1;
`endif

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  orig;
    logic [7:0]  res;
    logic [7:0]  pst;
    int          start_cyc;
  } exp_t;

  logic clk;
  logic rst;
  rmw_seq_if bus ();

  rmw_seq dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte-wide memory, one-cycle read latency, with a bench-side load port.
  logic [7:0] mem [0:255];
  logic       ld_en;
  logic [7:0] ld_a;
  logic [7:0] ld_v;
  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_v;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  exp_t sb[$];
  int   req = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: bus activity bookkeeping plus scoreboard checks on done.
  int          we_total = 0, re_total = 0, overlap = 0, we_base = 0;
  int          w_mark = 0, r_mark = 0, dw;
  logic [7:0]  last_wdata = 0, prev_wdata = 0;
  logic [15:0] last_waddr = 0;
  exp_t        e;
  always begin
    @(negedge clk);
    if (bus.mem_we === 1'b1) begin
      we_total++;
      prev_wdata = last_wdata;
      last_wdata = bus.mem_wdata;
      last_waddr = bus.mem_addr;
    end
    if (bus.mem_re === 1'b1) re_total++;
    if (bus.mem_re === 1'b1 && bus.mem_we === 1'b1) overlap++;
    if (req == 1) begin
      chk("reset_zero", {bus.busy, bus.done, bus.status_we, bus.mem_re, bus.mem_we,
                         bus.mem_addr, bus.mem_wdata, bus.result, bus.status_out}, 64'd0);
      w_mark = we_total;
      r_mark = re_total;
    end
    if (req == 2) chk("quiet_after_reset", {32'(we_total), 32'(re_total)}, {32'(w_mark), 32'(r_mark)});
    if (req == 3) begin
      chk("drain", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e  = sb.pop_front();
        dw = we_total - we_base;
        chk("result", 64'(bus.result), 64'(e.res));
        chk("status_out", 64'(bus.status_out), 64'(e.pst));
        chk("done_ctl", {bus.status_we, bus.busy, bus.mem_re, bus.mem_we}, 64'b1000);
        chk("latency", 64'(cyc), 64'(e.start_cyc + 5));
        chk("we_count", 64'(dw), 64'(EXP_WE));
        chk("wdata_first", 64'((dw == 2) ? prev_wdata : last_wdata),
            64'((EXP_WE == 2) ? e.orig : e.res));
        chk("wdata_final", 64'(last_wdata), 64'(e.res));
        chk("waddr", 64'(last_waddr), 64'(e.addr));
        chk("no_re_we_overlap", 64'(overlap), 64'd0);
      end
      we_base = we_total;
    end else if (bus.busy !== 1'b1) begin
      we_base = we_total;
    end
  end

  task automatic request(input int code);
    @(posedge clk);
    #1 req = code;
    @(negedge clk);
    #1 req = 0;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] v);
    @(negedge clk);
    ld_a = a; ld_v = v; ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic expect_op(input logic [15:0] a, input logic [7:0] v, input logic [7:0] r,
                           input logic [7:0] pe, input int sc);
    exp_t x;
    x.addr = a; x.orig = v; x.res = r; x.pst = pe; x.start_cyc = sc;
    sb.push_back(x);
  endtask

  task automatic drain();
    for (int i = 0; i < 16 && sb.size() != 0; i++) @(negedge clk);
    request(3);
  endtask

  task automatic run_op(input rmwop_t o, input logic [15:0] a, input logic [7:0] v,
                        input logic [7:0] p, input logic [7:0] r, input logic [7:0] pe);
    load(a[7:0], v);
    bus.op = o; bus.addr = a; bus.status_in = p; bus.start = 1'b1;
    expect_op(a, v, r, pe, cyc);
    @(negedge clk);
    bus.start = 1'b0;
    drain();
  endtask

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_a = 0; ld_v = 0;
    bus.start = 1'b0; bus.op = RMW_ASL; bus.addr = 0; bus.status_in = 0;
    repeat (2) @(negedge clk);
    request(1);
    rst = 1'b0;

    //        op       addr      mem    P_in   result P_out
    run_op(RMW_ASL, 16'h0210, 8'h81, 8'h20, 8'h02, 8'h21);
    run_op(RMW_ROR, 16'h0311, 8'h01, 8'h21, 8'h80, 8'hA1);
    run_op(RMW_INC, 16'h0412, 8'hFF, 8'h61, 8'h00, 8'h63);
    run_op(RMW_DEC, 16'h0513, 8'h00, 8'h2C, 8'hFF, 8'hAC);
    run_op(RMW_LSR, 16'h0614, 8'h01, 8'hB0, 8'h00, 8'h33);
    run_op(RMW_ROL, 16'h0715, 8'h55, 8'h27, 8'hAB, 8'hA4);
    run_op(RMW_INC, 16'h0816, 8'h7F, 8'h20, 8'h80, 8'hA0);
    run_op(RMW_DEC, 16'h0917, 8'h01, 8'h00, 8'h00, 8'h02);

    // start held through a whole op: the second ASL sees the first one's write
    load(8'h18, 8'h40);
    bus.op = RMW_ASL; bus.addr = 16'h1018; bus.status_in = 8'h20; bus.start = 1'b1;
    expect_op(16'h1018, 8'h40, 8'h80, 8'hA0, cyc);
    expect_op(16'h1018, 8'h80, 8'h00, 8'h23, cyc + 6);
    repeat (7) @(negedge clk);
    bus.start = 1'b0;
    drain();

    // reset during DUMMY: op must not complete and the bus must stay quiet
    load(8'h19, 8'h10);
    bus.op = RMW_INC; bus.addr = 16'h2019; bus.status_in = 8'h20; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    request(1);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    request(2);

    run_op(RMW_ASL, 16'h0210, 8'h81, 8'h20, 8'h02, 8'h21);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
